// File: rtl/rs_dispatch_if.sv
// Insqueue-to-reservation-station bundle: the decoded instruction handshake and the RS entry-write fields.
// The master drives the instruction and takes the entry; the slave (rs_dispatch) does the opposite.
interface rs_dispatch_if #(
  parameter int RS_W            = 4,
  parameter int INST_TYPE_WIDTH = 6
);
  logic                       iq_valid;
  logic                       iq_ready;
  logic [31:0]                iq_inst;
  logic [31:0]                iq_pc;
  logic [31:0]                iq_jumppc;
  logic [31:0]                iq_imm;
  logic [INST_TYPE_WIDTH-1:0] iq_ordertype;
  logic [4:0]                 iq_rs1;
  logic [4:0]                 iq_rs2;
  logic [4:0]                 iq_rd;
  logic                       iq_use_rs1;
  logic                       iq_use_rs2;
  logic                       iq_writes_rd;

  logic                       insqueue_to_RS_needchange;
  logic [RS_W-1:0]            r2;
  logic [31:0]                RS_s_vj_r2_;
  logic [31:0]                RS_s_vk_r2_;
  logic [31:0]                RS_s_qj_r2_;
  logic [31:0]                RS_s_qk_r2_;
  logic [31:0]                RS_s_inst_r2_;
  logic [31:0]                RS_s_pc_r2_;
  logic [31:0]                RS_s_jumppc_r2_;
  logic [31:0]                RS_s_A_r2_;
  logic [31:0]                RS_s_reorder_r2_;
  logic [INST_TYPE_WIDTH-1:0] RS_s_ordertype_r2_;
  logic                       RS_s_busy_r2_;

  modport master (
    output iq_valid, iq_inst, iq_pc, iq_jumppc, iq_imm, iq_ordertype,
           iq_rs1, iq_rs2, iq_rd, iq_use_rs1, iq_use_rs2, iq_writes_rd,
    input  iq_ready, insqueue_to_RS_needchange, r2,
           RS_s_vj_r2_, RS_s_vk_r2_, RS_s_qj_r2_, RS_s_qk_r2_, RS_s_inst_r2_,
           RS_s_pc_r2_, RS_s_jumppc_r2_, RS_s_A_r2_, RS_s_reorder_r2_,
           RS_s_ordertype_r2_, RS_s_busy_r2_
  );

  modport slave (
    input  iq_valid, iq_inst, iq_pc, iq_jumppc, iq_imm, iq_ordertype,
           iq_rs1, iq_rs2, iq_rd, iq_use_rs1, iq_use_rs2, iq_writes_rd,
    output iq_ready, insqueue_to_RS_needchange, r2,
           RS_s_vj_r2_, RS_s_vk_r2_, RS_s_qj_r2_, RS_s_qk_r2_, RS_s_inst_r2_,
           RS_s_pc_r2_, RS_s_jumppc_r2_, RS_s_A_r2_, RS_s_reorder_r2_,
           RS_s_ordertype_r2_, RS_s_busy_r2_
  );
endinterface

// File: rtl/rs_dispatch.sv
// Reservation-station dispatch: renames rs1/rs2 through a register-status table, allocates ROB tail and RS slot.
// Define RS_DISPATCH_BYPASS_EN to forward same-cycle CDB broadcasts; otherwise such hits stall dispatch one cycle.
module rs_dispatch #(
  parameter int RS_W            = 4,
  parameter int ROB_W           = 4,
  parameter int NREG            = 32,
  parameter int INST_TYPE_WIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              Clear_flag,
  rs_dispatch_if.slave      iq,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  input  logic              rob_full,
  input  logic [ROB_W-1:0]  rob_tail,
  output logic              rob_alloc,
  output logic [ROB_W-1:0]  rob_qtag1,
  output logic [ROB_W-1:0]  rob_qtag2,
  input  logic              rob_qready1,
  input  logic              rob_qready2,
  input  logic [31:0]       rob_qvalue1,
  input  logic [31:0]       rob_qvalue2,
  input  logic [RS_W-1:0]   RS_unbusy_pos,
  input  logic              rs_cdb_valid,
  input  logic [ROB_W-1:0]  b2,
  input  logic [31:0]       rs_cdb_value,
  input  logic              slb_cdb_valid,
  input  logic [ROB_W-1:0]  b4,
  input  logic [31:0]       slb_cdb_value,
  input  logic              commit_valid,
  input  logic [4:0]        commit_rd,
  input  logic [ROB_W-1:0]  commit_tag
);
  logic [NREG-1:0]  reg_busy_reg;
  logic [ROB_W-1:0] reg_tag_reg [NREG];
  logic             bypass_stall;
  logic             fire;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      logic [4:0]       idx;
      logic             use_op;
      logic [31:0]      rf_data;
      logic             rob_ready;
      logic [31:0]      rob_value;
      logic [ROB_W-1:0] tag;
      logic             pending;
      logic             rs_hit;
      logic             slb_hit;
      logic [31:0]      v;
      logic [31:0]      q;

      assign idx       = (gi == 0) ? iq.iq_rs1 : iq.iq_rs2;
      assign use_op    = (gi == 0) ? iq.iq_use_rs1 : iq.iq_use_rs2;
      assign rf_data   = (gi == 0) ? rf_rdata1 : rf_rdata2;
      assign rob_ready = (gi == 0) ? rob_qready1 : rob_qready2;
      assign rob_value = (gi == 0) ? rob_qvalue1 : rob_qvalue2;
      assign tag       = reg_tag_reg[idx];
      // Operand still waits on an in-flight producer whose ROB entry has no value yet.
      assign pending   = use_op && (idx != 5'd0) && reg_busy_reg[idx] && !rob_ready;
      assign rs_hit    = rs_cdb_valid && (b2 == tag);
      assign slb_hit   = slb_cdb_valid && (b4 == tag);

      always_comb begin
        v = 32'd0;
        q = 32'hFFFF_FFFF;
        if (!use_op || idx == 5'd0) begin
          v = 32'd0;
        end else if (!reg_busy_reg[idx]) begin
          v = rf_data;
        end else if (rob_ready) begin
          v = rob_value;
`ifdef RS_DISPATCH_BYPASS_EN
        end else if (rs_hit) begin
          v = rs_cdb_value;
        end else if (slb_hit) begin
          v = slb_cdb_value;
`endif
        end else begin
          q = {{(32-ROB_W){1'b0}}, tag};
        end
      end
    end
  endgenerate

`ifdef RS_DISPATCH_BYPASS_EN
  assign bypass_stall = 1'b0;
`else
  // The new entry is not yet busy in the RS and would miss this broadcast; retry once the ROB holds it.
  assign bypass_stall = (g_op[0].pending && (g_op[0].rs_hit || g_op[0].slb_hit)) ||
                        (g_op[1].pending && (g_op[1].rs_hit || g_op[1].slb_hit));
  logic unused_cdb_values;
  assign unused_cdb_values = ^{rs_cdb_value, slb_cdb_value};
`endif

  assign iq.iq_ready = rst && rdy && !Clear_flag && !rob_full &&
                       (RS_unbusy_pos != {RS_W{1'b1}}) && !bypass_stall;
  assign fire        = iq.iq_valid && iq.iq_ready;

  assign rob_alloc                    = fire;
  assign iq.insqueue_to_RS_needchange = fire;
  assign rf_raddr1                    = iq.iq_rs1;
  assign rf_raddr2                    = iq.iq_rs2;
  assign rob_qtag1                    = g_op[0].tag;
  assign rob_qtag2                    = g_op[1].tag;

  assign iq.r2                 = RS_unbusy_pos;
  assign iq.RS_s_vj_r2_        = g_op[0].v;
  assign iq.RS_s_qj_r2_        = g_op[0].q;
  assign iq.RS_s_vk_r2_        = g_op[1].v;
  assign iq.RS_s_qk_r2_        = g_op[1].q;
  assign iq.RS_s_inst_r2_      = iq.iq_inst;
  assign iq.RS_s_pc_r2_        = iq.iq_pc;
  assign iq.RS_s_jumppc_r2_    = iq.iq_jumppc;
  assign iq.RS_s_A_r2_         = iq.iq_imm;
  assign iq.RS_s_reorder_r2_   = {{(32-ROB_W){1'b0}}, rob_tail};
  assign iq.RS_s_ordertype_r2_ = iq.iq_ordertype;
  assign iq.RS_s_busy_r2_      = 1'b1;

  // Rename after commit so a same-cycle dispatch to the same rd keeps the new mapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_busy_reg <= '0;
      for (int i = 0; i < NREG; i++) reg_tag_reg[i] <= '0;
    end else if (rdy) begin
      if (Clear_flag) begin
        reg_busy_reg <= '0;
      end else begin
        if (commit_valid && reg_busy_reg[commit_rd] && (reg_tag_reg[commit_rd] == commit_tag))
          reg_busy_reg[commit_rd] <= 1'b0;
        if (fire && iq.iq_writes_rd && (iq.iq_rd != 5'd0)) begin
          reg_busy_reg[iq.iq_rd] <= 1'b1;
          reg_tag_reg[iq.iq_rd]  <= rob_tail;
        end
      end
    end
  end
endmodule
